// File: rtl/merger_4_ctrl.sv
// merger_4_ctrl: sequencing controller for the 8-input bitonic merge network of
// the 4-merger. Merges two ascending tuple streams (A, B) into one ascending
// stream, keeping exactly one tuple in flight through the network.
// Optional statistics counters are enabled by defining MERGER_CTRL_STAT_EN.
module merger_4_ctrl #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*DATA_WIDTH-1:0] i_a_data,
  input  logic                    i_a_valid,
  input  logic                    i_a_last,
  output logic                    o_a_ready,
  input  logic [4*DATA_WIDTH-1:0] i_b_data,
  input  logic                    i_b_valid,
  input  logic                    i_b_last,
  output logic                    o_b_ready,
  output logic [4*DATA_WIDTH-1:0] o_out_data,
  output logic                    o_out_valid,
  output logic                    o_out_last,
  input  logic                    i_out_ready,
  output logic [4*DATA_WIDTH-1:0] o_net_elems_0,
  output logic [4*DATA_WIDTH-1:0] o_net_elems_1,
  output logic                    o_net_stall,
  output logic                    o_net_switch_output,
  output logic [4*DATA_WIDTH-1:0] o_net_top_tuple,
  input  logic [4*DATA_WIDTH-1:0] i_net_elems_0,
  input  logic [4*DATA_WIDTH-1:0] i_net_elems_1
`ifdef MERGER_CTRL_STAT_EN
  ,
  output logic [31:0]             o_stat_tuples,
  output logic [31:0]             o_stat_block_cycles
`endif
);

  localparam int unsigned TW = 4 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, FILL, SELECT, W1, W2, RESULT, FLUSH
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   fb;
  logic            a_done, b_done;

  logic            sel_b, sel_ok, sel_last;
  logic [TW-1:0]   sel_data;
  logic            slot_free;
  logic            take, issue;
  logic            fb_ld_sel, fb_ld_net;
  logic            out_ld_net, out_ld_fb;

  // Pick the side whose head is smaller; a finished stream forces the other side.
  always_comb begin
    sel_b  = 1'b0;
    sel_ok = 1'b0;
    if (a_done) begin
      sel_b  = 1'b1;
      sel_ok = i_b_valid;
    end else if (b_done) begin
      sel_b  = 1'b0;
      sel_ok = i_a_valid;
    end else begin
      sel_b  = !(i_a_data[DATA_WIDTH-1:0] <= i_b_data[DATA_WIDTH-1:0]);
      sel_ok = i_a_valid && i_b_valid;
    end
  end

  assign sel_data  = sel_b ? i_b_data : i_a_data;
  assign sel_last  = sel_b ? i_b_last : i_a_last;
  assign slot_free = !o_out_valid || i_out_ready;

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    take       = 1'b0;
    issue      = 1'b0;
    fb_ld_sel  = 1'b0;
    fb_ld_net  = 1'b0;
    out_ld_net = 1'b0;
    out_ld_fb  = 1'b0;
    case (state)
      IDLE: state_nxt = FILL;
      FILL: begin
        if (sel_ok) begin
          take      = 1'b1;
          fb_ld_sel = 1'b1;
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        if (a_done && b_done) begin
          state_nxt = FLUSH;
        end else if (sel_ok) begin
          take      = 1'b1;
          issue     = 1'b1;
          state_nxt = W1;
        end
      end
      W1:     state_nxt = W2;
      W2:     state_nxt = RESULT;
      RESULT: begin
        if (slot_free) begin
          out_ld_net = 1'b1;
          fb_ld_net  = 1'b1;
          state_nxt  = SELECT;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_ld_fb = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_a_ready           = take && !sel_b;
  assign o_b_ready           = take && sel_b;
  assign o_net_stall         = !issue;
  assign o_net_switch_output = issue && sel_b;
  assign o_net_elems_0       = sel_data;
  assign o_net_elems_1       = fb;
  assign o_net_top_tuple     = '0;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Stream-done flags: set when a last tuple is dequeued, cleared in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_done <= 1'b0;
      b_done <= 1'b0;
    end else if (state == IDLE) begin
      a_done <= 1'b0;
      b_done <= 1'b0;
    end else if (take && sel_last) begin
      if (sel_b) b_done <= 1'b1;
      else       a_done <= 1'b1;
    end
  end

  // Feedback tuple: first tuple of a merge, then the network's upper half.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       fb <= '0;
    else if (fb_ld_sel) fb <= sel_data;
    else if (fb_ld_net) fb <= i_net_elems_1;
  end

  // Output slot: lower half of each result, then the residual feedback as last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_data  <= '0;
      o_out_last  <= 1'b0;
      o_out_valid <= 1'b0;
    end else if (out_ld_net) begin
      o_out_data  <= i_net_elems_0;
      o_out_last  <= 1'b0;
      o_out_valid <= 1'b1;
    end else if (out_ld_fb) begin
      o_out_data  <= fb;
      o_out_last  <= 1'b1;
      o_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

`ifdef MERGER_CTRL_STAT_EN
  // Handshake and backpressure counters; free-running, wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_tuples       <= 32'd0;
      o_stat_block_cycles <= 32'd0;
    end else begin
      if (o_out_valid && i_out_ready)
        o_stat_tuples <= o_stat_tuples + 32'd1;
      if ((state == RESULT || state == FLUSH) && !slot_free)
        o_stat_block_cycles <= o_stat_block_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_merger_4_ctrl.sv
// tb_merger_4_ctrl: directed bench for merger_4_ctrl with a behavioural
// 3-cycle sorting network and a scoreboard of expected merged tuples.
// Define MERGER_CTRL_STAT_EN to also exercise the statistics counters.
module tb_merger_4_ctrl;

  localparam int unsigned DW = 128;
  localparam int unsigned TW = 4 * DW;

  typedef logic [TW-1:0] tuple_t;
  typedef struct {
    tuple_t data;
    logic   last;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  tuple_t a_data, b_data;
  logic   a_valid, a_last, a_ready;
  logic   b_valid, b_last, b_ready;
  tuple_t out_data;
  logic   out_valid, out_last, out_ready;
  tuple_t net_e0, net_e1, net_top;
  logic   net_stall, net_sw;
  tuple_t net_r0, net_r1;
`ifdef MERGER_CTRL_STAT_EN
  logic [31:0] stat_tuples, stat_block;
`endif

  merger_4_ctrl #(.DATA_WIDTH(DW)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_a_data            (a_data),
    .i_a_valid           (a_valid),
    .i_a_last            (a_last),
    .o_a_ready           (a_ready),
    .i_b_data            (b_data),
    .i_b_valid           (b_valid),
    .i_b_last            (b_last),
    .o_b_ready           (b_ready),
    .o_out_data          (out_data),
    .o_out_valid         (out_valid),
    .o_out_last          (out_last),
    .i_out_ready         (out_ready),
    .o_net_elems_0       (net_e0),
    .o_net_elems_1       (net_e1),
    .o_net_stall         (net_stall),
    .o_net_switch_output (net_sw),
    .o_net_top_tuple     (net_top),
    .i_net_elems_0       (net_r0),
    .i_net_elems_1       (net_r1)
`ifdef MERGER_CTRL_STAT_EN
    ,
    .o_stat_tuples       (stat_tuples),
    .o_stat_block_cycles (stat_block)
`endif
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     out_count = 0;
  int     total_hs = 0;
  int     min_gap = 1000;
  int     last_issue = -1000;
  bit     both_seen = 0;
  bit     a_en = 1, b_en = 1;
  tuple_t a_q[$], b_q[$];
  exp_t   sb[$];
  int     acc[$];

  // Network model pipeline: issue -> d1 -> d2 -> visible result.
  tuple_t d1_lo = '0, d1_hi = '0, d2_lo = '0, d2_hi = '0;
  bit     v1 = 0, v2 = 0;

  function automatic tuple_t mk(input int e0, input int e1, input int e2, input int e3);
    tuple_t t;
    t = '0;
    t[0*DW +: DW] = DW'(e0);
    t[1*DW +: DW] = DW'(e1);
    t[2*DW +: DW] = DW'(e2);
    t[3*DW +: DW] = DW'(e3);
    return t;
  endfunction

  task automatic check(input string tag, input tuple_t got, input tuple_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sorts all eight elements of two tuples; returns lower and upper four.
  task automatic sort8(input tuple_t x, input tuple_t y, output tuple_t lo, output tuple_t hi);
    logic [DW-1:0] e[8];
    logic [DW-1:0] t;
    for (int i = 0; i < 4; i++) begin
      e[i]     = x[i*DW +: DW];
      e[i + 4] = y[i*DW +: DW];
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (e[j] > e[j + 1]) begin
          t = e[j]; e[j] = e[j + 1]; e[j + 1] = t;
        end
    lo = '0;
    hi = '0;
    for (int i = 0; i < 4; i++) begin
      lo[i*DW +: DW] = e[i];
      hi[i*DW +: DW] = e[i + 4];
    end
  endtask

  // Expected merged stream: all queued elements sorted, chunked by four.
  task automatic expect_from_queues();
    logic [DW-1:0] el[$];
    logic [DW-1:0] t;
    exp_t e;
    int n;
    foreach (a_q[i]) for (int k = 0; k < 4; k++) el.push_back(a_q[i][k*DW +: DW]);
    foreach (b_q[i]) for (int k = 0; k < 4; k++) el.push_back(b_q[i][k*DW +: DW]);
    for (int i = 1; i < el.size(); i++)
      for (int j = i; j > 0; j--)
        if (el[j - 1] > el[j]) begin
          t = el[j]; el[j] = el[j - 1]; el[j - 1] = t;
        end
    n = el.size() / 4;
    for (int i = 0; i < n; i++) begin
      e.data = '0;
      for (int k = 0; k < 4; k++) e.data[k*DW +: DW] = el[4*i + k];
      e.last = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive();
    a_valid = a_en && (a_q.size() > 0);
    a_data  = (a_q.size() > 0) ? a_q[0] : '0;
    a_last  = (a_q.size() == 1);
    b_valid = b_en && (b_q.size() > 0);
    b_data  = (b_q.size() > 0) ? b_q[0] : '0;
    b_last  = (b_q.size() == 1);
  endtask

  task automatic test_begin();
    acc.delete();
    both_seen  = 0;
    min_gap    = 1000;
    last_issue = -1000;
    out_count  = 0;
  endtask

  // One clock: sample at negedge, advance sources and network after posedge.
  task automatic step();
    bit     at, bt, iss;
    tuple_t lo, hi;
    exp_t   e;
    lo = '0;
    hi = '0;
    @(negedge clk);
    at  = a_ready;
    bt  = b_ready;
    iss = !net_stall;
    if (at && bt) both_seen = 1;
    if (at) acc.push_back(0);
    if (bt) acc.push_back(1);
    if (iss) begin
      sort8(net_e0, net_e1, lo, hi);
      if (cyc - last_issue < min_gap) min_gap = cyc - last_issue;
      last_issue = cyc;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_data, '0);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", TW'(out_last), TW'(e.last));
      end
      out_count++;
      total_hs++;
    end
    @(posedge clk);
    #1;
    if (at && a_q.size() > 0) a_q.delete(0);
    if (bt && b_q.size() > 0) b_q.delete(0);
    if (v2) begin
      net_r0 = d2_lo;
      net_r1 = d2_hi;
    end
    d2_lo = d1_lo; d2_hi = d1_hi; v2 = v1;
    d1_lo = lo;    d1_hi = hi;    v1 = iss;
    cyc++;
    drive();
  endtask

  task automatic run_outputs(input int n, input string tag);
    int guard;
    guard = 0;
    while (out_count < n && guard < 400) begin
      step();
      guard++;
    end
    check({tag, "_outputs"}, TW'(out_count), TW'(n));
    check({tag, "_sb_empty"}, TW'(sb.size()), '0);
    check({tag, "_no_dual_ready"}, TW'(both_seen), '0);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, TW'(out_valid), '0);
    check({tag, "_out_last"}, TW'(out_last), '0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_net_stall"}, TW'(net_stall), TW'(1));
    check({tag, "_a_ready"}, TW'(a_ready), '0);
    check({tag, "_b_ready"}, TW'(b_ready), '0);
    check({tag, "_switch"}, TW'(net_sw), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    net_r0    = '0;
    net_r1    = '0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive();
    check_reset_vals("rst0");
    rst_n = 1'b1;
    step();
    step();

    // Two single-tuple streams: FILL takes A, the only issue takes B.
    test_begin();
    a_q.push_back(mk(1, 3, 5, 7));
    b_q.push_back(mk(2, 4, 6, 8));
    expect_from_queues();
    drive();
    run_outputs(2, "t1");
    check("t1_acc_n", TW'(acc.size()), TW'(2));
    check("t1_fill_a", TW'(acc[0]), '0);
    check("t1_issue_b", TW'(acc[1]), TW'(1));

    // Three tuples; issues must be at least four cycles apart.
    test_begin();
    a_q.push_back(mk(1, 2, 3, 4));
    a_q.push_back(mk(9, 10, 11, 12));
    b_q.push_back(mk(5, 6, 7, 8));
    expect_from_queues();
    drive();
    run_outputs(3, "t2");
    check("t2_gap_ge4", TW'(min_gap >= 4), TW'(1));

    // Equal heads resolve to A.
    test_begin();
    a_q.push_back(mk(5, 6, 7, 8));
    b_q.push_back(mk(5, 9, 10, 11));
    expect_from_queues();
    drive();
    run_outputs(2, "t3");
    check("t3_tie_a", TW'(acc[0]), '0);

    // Backpressure while a result is pending.
    test_begin();
    out_ready = 1'b0;
    a_q.push_back(mk(1, 2, 3, 4));
    a_q.push_back(mk(9, 10, 11, 12));
    b_q.push_back(mk(5, 6, 7, 8));
    expect_from_queues();
    drive();
    repeat (15) step();
    check("t4_out_valid", TW'(out_valid), TW'(1));
    check("t4_held_data", out_data, mk(1, 2, 3, 4));
    check("t4_acc_before", TW'(acc.size()), TW'(3));
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_stall", TW'(net_stall), TW'(1));
      check("t4_stable", out_data, mk(1, 2, 3, 4));
    end
    check("t4_no_accept", TW'(acc.size()), TW'(3));
`ifdef MERGER_CTRL_STAT_EN
    check("t4_stat_block", TW'(stat_block >= 32'd10), TW'(1));
`endif
    out_ready = 1'b1;
    run_outputs(3, "t4");

    // B not valid yet: nothing may be taken from A.
    test_begin();
    b_en = 0;
    a_q.push_back(mk(1, 2, 3, 4));
    drive();
    repeat (6) step();
    check("t5_no_accept", TW'(acc.size()), '0);
    b_q.push_back(mk(0, 0, 0, 0));
    b_en = 1;
    expect_from_queues();
    drive();
    run_outputs(2, "t5");
    check("t5_b_first", TW'(acc[0]), TW'(1));

    // Reset two cycles after an issue, then a clean stream.
    test_begin();
    a_q.push_back(mk(1, 3, 5, 7));
    a_q.push_back(mk(20, 21, 22, 23));
    b_q.push_back(mk(2, 4, 6, 8));
    drive();
    for (int g = 0; g < 30 && last_issue < 0; g++) step();
    check("t6_issue_seen", TW'(last_issue >= 0), TW'(1));
    step();
    step();
    rst_n = 1'b0;
    a_q.delete();
    b_q.delete();
    sb.delete();
    total_hs = 0;
    drive();
    check_reset_vals("rst1");
    rst_n = 1'b1;
    step();
    test_begin();
    a_q.push_back(mk(10, 11, 12, 13));
    b_q.push_back(mk(14, 15, 16, 17));
    expect_from_queues();
    drive();
    run_outputs(2, "t6");
`ifdef MERGER_CTRL_STAT_EN
    step();
    check("stat_tuples", TW'(stat_tuples), TW'(total_hs));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/merger_4_ctrl.md
# merger_4_ctrl

Sequencing controller for the 8-input bitonic merge network used in the 4-merger. It merges two ascending streams of 4-element tuples (A and B) into one ascending output stream. Each cycle it picks the input tuple with the smaller head element and drives the network with that tuple plus the fed-back upper half of the previous result. It pulses the network's stall input so that exactly one tuple is in flight, then captures the lower half as output.

## Interface
- DATA_WIDTH, 128, width of one element; tuples are 4*DATA_WIDTH, lane k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH], lane 0 smallest.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_a_data / i_b_data  in  4*DATA_WIDTH  head tuple of stream A / B, ascending
- i_a_valid / i_b_valid  in  1  head tuple valid
- i_a_last / i_b_last  in  1  head tuple is last of its stream
- o_a_ready / o_b_ready  out  1  dequeue strobe, combinational
- o_out_data  out  4*DATA_WIDTH  merged tuple
- o_out_valid  out  1  output valid
- o_out_last  out  1  final tuple of merged stream
- i_out_ready  in  1  downstream accept
- o_net_elems_0 / o_net_elems_1  out  4*DATA_WIDTH  network inputs: selected tuple / feedback tuple
- o_net_stall  out  1  network stall
- o_net_switch_output  out  1  source of issued tuple (0=A, 1=B)
- o_net_top_tuple  out  4*DATA_WIDTH  tied to 0
- i_net_elems_0 / i_net_elems_1  in  4*DATA_WIDTH  network lower / upper result

## Operation
- Registers: fb (feedback tuple), a_done, b_done, out register, state.
- Selection rule: if a_done, pick B. If b_done, pick A. Otherwise both heads must be valid; pick A if A.lane0 <= B.lane0 (unsigned, ties to A), else B. The chosen side must be valid.
- Accept = chosen ready && valid. Accepting a tuple with last set sets the matching done flag.
- States:
  - IDLE: a_done = b_done = 0; go to FILL.
  - FILL: when the selection is possible, accept the chosen tuple into fb (not sent to the network) and go to SELECT.
  - SELECT:
    - If a_done && b_done, go to FLUSH.
    - Else, when the selection is possible, accept it; o_net_elems_0 = chosen, o_net_elems_1 = fb, o_net_stall = 0, o_net_switch_output = side; go to W1.
  - W1 → W2 → RESULT, unconditionally.
  - RESULT: if out slot free (!o_out_valid || i_out_ready): out_data ← i_net_elems_0, out_last ← 0, out_valid ← 1, fb ← i_net_elems_1, then go to SELECT. Otherwise hold.
  - FLUSH: if out slot free: out_data ← fb, out_last ← 1, out_valid ← 1, then go to IDLE.
- o_net_stall = 1 in every cycle except the issue cycle. The network is frozen, so its result stays stable until the next issue.
- o_out_valid clears on i_out_ready when no new load occurs in the same cycle.
- A stream whose first tuple carries last contributes exactly one tuple.

## Timing
- Reset (async, i_rst_n low): state = IDLE, o_out_valid = 0, o_out_last = 0, o_out_data = 0, fb = 0, done flags = 0, o_net_stall = 1, ready outputs = 0, o_net_switch_output = 0.
- Issue in cycle t: the network result is valid on i_net_elems_* from cycle t+3 and is sampled in RESULT at cycle t+3.
- Maximum throughput is one tuple per 4 cycles. Output tuple n appears 1 cycle after its RESULT capture.
- Backpressure is absorbed in RESULT/FLUSH. No input is accepted while the out slot is blocked.
- Reset asserted mid-flight discards the in-flight tuple; the network is not flushed (the next issue overwrites it).
- o_a_ready and o_b_ready are never high in the same cycle.

## Configuration
- MERGER_CTRL_STAT_EN defined: adds outputs o_stat_tuples (32 bits) and o_stat_block_cycles (32 bits).
  - o_stat_tuples counts output handshakes.
  - o_stat_block_cycles counts cycles in RESULT or FLUSH with the out slot not free.
  - Both reset to 0, wrap at 2^32, and never clear in IDLE.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- A = {1,3,5,7} last, B = {2,4,6,8} last, i_out_ready = 1 → outputs {1,2,3,4}, then {5,6,7,8} with last. FILL takes A and the single issue takes B.
- A = {1,2,3,4}, {9,10,11,12} last; B = {5,6,7,8} last → outputs {1,2,3,4}, {5,6,7,8}, {9,10,11,12} with last. Issue-cycle spacing ≥ 4.
- Tie: A.lane0 = B.lane0 = 5 → A accepted first; o_a_ready and o_b_ready never both high.
- i_out_ready = 0 for 10 cycles during RESULT → no further accepts, o_out_data stable, o_net_stall = 1; release → sequence resumes unchanged.
- i_b_valid = 0 while B is not done → no accept from A even if A is valid. Then B = {0,0,0,0} last → B is chosen first.
- Reset pulse 2 cycles after an issue → all outputs at reset values. A following clean stream produces correct output with no stale tuple.
